// File: rtl/mac_operand_arbiter.sv
// Round-robin arbiter/sequencer sharing the MAC operand path between the
// matrix load unit (A) and the CPU register-file port (B). The winning beat
// is captured in a one-entry output register with a valid/ready handshake.
// Bursts end on a last flag, on a dropped valid, or by forced preemption
// after MAX_BURST beats while the other requester is waiting.
module mac_operand_arbiter #(
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 8,
  parameter int CNT_W     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_valid,
  input  logic [DATA_W-1:0] a_data,
  input  logic              a_last,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [DATA_W-1:0] b_data,
  input  logic              b_last,
  output logic              b_ready,
  output logic              sel,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              out_src,
  input  logic              out_ready,
  output logic              preempt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_A = 2'd1,
    GNT_B = 2'd2
  } state_t;

  state_t             state;
  state_t             state_next;
  logic               last_grant;   // 0 = A was served last, 1 = B
  logic [CNT_W-1:0]   beat_cnt;

  logic               can_load;
  logic               g_src;
  logic               g_valid;
  logic               g_last;
  logic [DATA_W-1:0]  g_data;
  logic               o_valid;
  logic               xfer;
  logic               cnt_max;
  logic               rel_last;
  logic               rel_pre;
  logic               rel_drop;
  logic               release_g;

  // Round-robin pick: a lone requester wins, a tie goes to whoever was not
  // served last.
  function automatic state_t arbitrate(input logic av, input logic bv,
                                       input logic lg);
    state_t s;
    s = IDLE;
    if (av && bv)  s = lg ? GNT_A : GNT_B;
    else if (av)   s = GNT_A;
    else if (bv)   s = GNT_B;
    return s;
  endfunction

  // The output register can take a new beat when empty or being drained.
  assign can_load = !out_valid || out_ready;
  assign a_ready  = (state == GNT_A) && can_load;
  assign b_ready  = (state == GNT_B) && can_load;

  // Route the granted requester, detect transfers and release conditions,
  // and form the next grant.
  always_comb begin
    g_src     = (state == GNT_B);
    g_valid   = g_src ? b_valid : a_valid;
    g_last    = g_src ? b_last  : a_last;
    g_data    = g_src ? b_data  : a_data;
    o_valid   = g_src ? a_valid : b_valid;
    xfer      = (a_ready && a_valid) || (b_ready && b_valid);
    cnt_max   = (beat_cnt == CNT_W'(MAX_BURST - 1));
    rel_last  = xfer && g_last;
    rel_pre   = xfer && !g_last && cnt_max && o_valid;
    // A stalled output freezes the grant even if the requester drops valid.
    rel_drop  = (state != IDLE) && can_load && !g_valid;
    release_g = rel_last || rel_pre || rel_drop;
    state_next = state;
    if (state == IDLE)
      state_next = arbitrate(a_valid, b_valid, last_grant);
    else if (release_g)
      // The releasing requester becomes last_grant, so arbitrate against it.
      state_next = arbitrate(a_valid, b_valid, g_src);
  end

  // Grant FSM, beat counter and registered output stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sel        <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_last   <= 1'b0;
      out_src    <= 1'b0;
      preempt    <= 1'b0;
      beat_cnt   <= '0;
      last_grant <= 1'b1;
    end else begin
      state   <= state_next;
      if (state_next != IDLE)
        sel <= (state_next == GNT_B);
      preempt <= rel_pre;

      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= g_data;
        out_last  <= g_last;
        out_src   <= g_src;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      // Counter saturates at MAX_BURST-1 when nobody is waiting.
      if (release_g) begin
        last_grant <= g_src;
        beat_cnt   <= '0;
      end else if (xfer && !cnt_max) begin
        beat_cnt <= beat_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: doc/mac_operand_arbiter.md
Name: mac_operand_arbiter

Overview:
- Round-robin arbiter and sequencer that shares the 32-bit operand path into the matrix MAC between two requesters: A (matrix load unit) and B (CPU register-file port).
- Drives the select of the downstream 32-bit 2:1 operand mux: sel=0 routes A, sel=1 routes B.
- Registers the winning beat into a one-entry output stage with valid/ready handshake.
- Supports bursts with a last flag and forced preemption after MAX_BURST beats.

Parameters:
DATA_W, 32, operand width
MAX_BURST, 8, max beats per grant while the other requester waits (≥2)
CNT_W, 4, beat counter width, ≥ clog2(MAX_BURST)+1

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
a_valid  in  1  requester A beat valid
a_data  in  DATA_W  requester A operand
a_last  in  1  requester A final beat of burst
a_ready  out  1  A beat accepted this cycle
b_valid  in  1  requester B beat valid
b_data  in  DATA_W  requester B operand
b_last  in  1  requester B final beat of burst
b_ready  out  1  B beat accepted this cycle
sel  out  1  mux select, 0=A 1=B
out_valid  out  1  output register holds a beat
out_data  out  DATA_W  registered operand to MAC
out_last  out  1  last flag of held beat
out_src  out  1  source of held beat, 0=A 1=B
out_ready  in  1  MAC consumes beat
preempt  out  1  one-cycle pulse on forced release at MAX_BURST

Behaviour:
- Reset (async, rst_n=0): state=IDLE, sel=0, out_valid=0, out_data=0, out_last=0, out_src=0, a_ready=b_ready=0, preempt=0, beat_cnt=0, last_grant=B (A has priority first).
- States: IDLE, GNT_A, GNT_B. sel is registered and equals the current grant; it holds its previous value in IDLE.
- Arbitration (IDLE, or on release):
  - Only one valid → that requester wins.
  - Both valid → the requester not equal to last_grant wins.
  - Neither valid → IDLE.
  - Grant is registered: the first beat can transfer the cycle after the decision.
- can_load = !out_valid || out_ready.
- a_ready = (state==GNT_A) && can_load (combinational from state and out_ready); b_ready likewise for GNT_B. The ungranted requester's ready is always 0.
- Transfer: valid && ready of the granted requester. On transfer:
  - out_data, out_last and out_src are loaded, out_valid=1.
  - beat_cnt increments.
- out_valid clears on out_ready && out_valid with no same-cycle transfer. Simultaneous consume and load gives a full-throughput back-to-back beat.
- Release of grant (evaluated at end of cycle):
  - (a) transfer with last=1;
  - (b) transfer when beat_cnt==MAX_BURST-1 and the other requester is valid → preempt=1 for that cycle;
  - (c) granted valid is low in a grant cycle.
- On release:
  - last_grant is set to the releasing requester, beat_cnt=0.
  - Next state comes directly from the arbitration rule, with no idle bubble if anyone is valid.
- At beat_cnt==MAX_BURST-1 with the other requester idle: no preemption. The counter saturates at MAX_BURST-1 and the burst continues.
- A preempted requester must keep its valid and data stable. Its remaining beats resume on its next grant.
- out_ready low: output held stable, granted ready=0, state and counter frozen.
- Reset mid-burst: all state and outputs return to reset values immediately, and the held beat is discarded.

Test Plan:
- Reset: rst_n=0 mid-traffic with out_valid=1 → all outputs 0 asynchronously, before the next clk edge. After release, first simultaneous a_valid/b_valid → A granted (sel=0).
- Single beats both requesters: a_valid=b_valid=1, last=1 always, out_ready=1 → out_src sequence 0,1,0,1. out_data matches the alternating a_data/b_data. One beat per cycle after the initial grant cycle.
- Burst no contention: A sends 12 beats, last on 12th, b_valid=0 → all 12 beats pass under GNT_A, preempt never asserted, sel stays 0.
- Preemption: A continuous, last=0, b_valid=1 throughout, MAX_BURST=8 → preempt pulses on A's 8th transfer. Next beat is from B, and A regains the grant after B's last.
- Backpressure: out_ready=0 for 5 cycles mid-burst → out_data/out_valid stable, a_ready=0, beat_cnt unchanged. Burst resumes with no lost or duplicated beats (compare against a scoreboard).
- Valid drop: A granted, a_valid falls for one cycle with b_valid=1 → grant moves to B on the next cycle. A is served after B releases.
